// File: rtl/ber_pkg.sv
// Shared definitions for the multi-channel PRBS BER checker:
// per-lane FSM states and the PRBS polynomial tap lookup.
package ber_pkg;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_COUNT  = 2'd2
    } lane_state_t;

    typedef struct packed {
        logic [4:0] hi;
        logic [4:0] lo;
    } prbs_taps_t;

    // 1-based feedback taps of the standard PRBS polynomials x^hi + x^lo + 1.
    function automatic prbs_taps_t prbs_taps(input int order);
        prbs_taps_t t;
        case (order)
            7:       t = '{hi: 5'd7,  lo: 5'd6};
            15:      t = '{hi: 5'd15, lo: 5'd14};
            23:      t = '{hi: 5'd23, lo: 5'd18};
            31:      t = '{hi: 5'd31, lo: 5'd28};
            default: t = '{hi: 5'd9,  lo: 5'd5};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ber_lane.sv
// One BER checker channel: self-seeding PRBS LFSR, SEED/VERIFY/COUNT FSM,
// per-window error tracking and saturating cumulative counters.
module ber_lane
    import ber_pkg::*;
#(
    parameter int PRBS_ORDER = 9,
    parameter int LOCK_LEN   = 511,
    parameter int WIN_LEN    = 1023,
    parameter int ERR_THR    = 0,
    parameter int LOSS_THR   = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_rx_bit,
    input  logic             i_clr_cnt,
    output logic             o_locked,
    output logic             o_ber_ok,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_bit_cnt
);

    localparam prbs_taps_t TAPS   = prbs_taps(PRBS_ORDER);
    localparam int         TAP_HI = int'(TAPS.hi);
    localparam int         TAP_LO = int'(TAPS.lo);
    localparam int         RUN_W  = $clog2(LOCK_LEN + 1);
    localparam int         WIN_W  = $clog2(WIN_LEN + 1);

    lane_state_t           state, state_nxt;
    logic [PRBS_ORDER-1:0] lfsr;
    logic [4:0]            seed_cnt;
    logic [RUN_W-1:0]      run_cnt;
    logic [WIN_W-1:0]      win_bits, win_err, win_err_inc;
    logic                  pred_bit, bit_err, seed_done, run_done, win_end, loss;
    logic                  lfsr_in, counting;

    // Bit 0 holds the newest symbol, so tap n sits at index n-1.
    assign pred_bit    = lfsr[TAP_HI-1] ^ lfsr[TAP_LO-1];
    assign bit_err     = pred_bit ^ i_rx_bit;
    assign seed_done   = (seed_cnt == 5'(PRBS_ORDER - 1));
    assign run_done    = (run_cnt == RUN_W'(LOCK_LEN - 1));
    assign win_end     = (win_bits == WIN_W'(WIN_LEN - 1));
    assign win_err_inc = win_err + WIN_W'(bit_err);
    assign loss        = (32'(win_err_inc) >= LOSS_THR);

    always_ff @(posedge clk) begin
        if (i_reset) state <= ST_SEED;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_en) begin
            case (state)
                ST_SEED:   if (seed_done) state_nxt = ST_VERIFY;
                ST_VERIFY: begin
                    if (bit_err)       state_nxt = ST_SEED;
                    else if (run_done) state_nxt = ST_COUNT;
                end
                ST_COUNT:  if (loss) state_nxt = ST_SEED;
                default:   state_nxt = ST_SEED;
            endcase
        end
    end

    // While seeding the LFSR swallows received bits; afterwards it free-runs.
    always_comb begin
        lfsr_in  = pred_bit;
        counting = 1'b0;
        case (state)
            ST_SEED:  lfsr_in  = i_rx_bit;
            ST_COUNT: counting = i_en;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            lfsr     <= '1;
            seed_cnt <= '0;
            run_cnt  <= '0;
            win_bits <= '0;
            win_err  <= '0;
            o_locked <= 1'b0;
            o_ber_ok <= 1'b0;
        end else if (i_en) begin
            lfsr     <= {lfsr[PRBS_ORDER-2:0], lfsr_in};
            seed_cnt <= (state == ST_SEED && !seed_done) ? seed_cnt + 5'd1 : 5'd0;
            run_cnt  <= (state == ST_VERIFY && !bit_err && !run_done) ? run_cnt + RUN_W'(1) : '0;
            o_locked <= (state_nxt == ST_COUNT);
            if (counting) begin
                if (loss) begin
                    win_bits <= '0;
                    win_err  <= '0;
                    o_ber_ok <= 1'b0;
                end else if (win_end) begin
                    win_bits <= '0;
                    win_err  <= '0;
                    o_ber_ok <= (32'(win_err_inc) <= ERR_THR);
                end else begin
                    win_bits <= win_bits + WIN_W'(1);
                    win_err  <= win_err_inc;
                end
            end
        end
    end

    // Cumulative counters saturate; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (i_reset || i_clr_cnt) begin
            o_err_cnt <= '0;
            o_bit_cnt <= '0;
        end else if (counting) begin
            if (o_bit_cnt != '1)            o_bit_cnt <= o_bit_cnt + CNT_W'(1);
            if (bit_err && o_err_cnt != '1) o_err_cnt <= o_err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ber_checker_nch.sv
// N_CH independent PRBS bit-error-rate checkers sharing one symbol strobe,
// with per-channel counters packed into wide output buses.
module ber_checker_nch
    import ber_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int PRBS_ORDER = 9,
    parameter int LOCK_LEN   = 511,
    parameter int WIN_LEN    = 1023,
    parameter int ERR_THR    = 0,
    parameter int LOSS_THR   = 64,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_en_rate1,
    input  logic [N_CH-1:0]       i_rx_bits,
    input  logic                  i_clr_cnt,
    output logic [N_CH-1:0]       o_locked,
    output logic [N_CH-1:0]       o_ber_ok,
    output logic [N_CH*CNT_W-1:0] o_err_cnt,
    output logic [N_CH*CNT_W-1:0] o_bit_cnt
);

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        ber_lane #(
            .PRBS_ORDER (PRBS_ORDER),
            .LOCK_LEN   (LOCK_LEN),
            .WIN_LEN    (WIN_LEN),
            .ERR_THR    (ERR_THR),
            .LOSS_THR   (LOSS_THR),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk       (clk),
            .i_reset   (i_reset),
            .i_en      (i_en_rate1),
            .i_rx_bit  (i_rx_bits[k]),
            .i_clr_cnt (i_clr_cnt),
            .o_locked  (o_locked[k]),
            .o_ber_ok  (o_ber_ok[k]),
            .o_err_cnt (o_err_cnt[k*CNT_W +: CNT_W]),
            .o_bit_cnt (o_bit_cnt[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_ber_checker_nch.sv
// Bench for ber_checker_nch: a phase table plus hand-written corner sequences,
// with a queue-of-history reference model compared on every clock.
module tb_ber_checker_nch;

    localparam int     N_CH     = 2;
    localparam int     ORDER    = 9;
    localparam int     TAP_A    = 9;
    localparam int     TAP_B    = 5;
    localparam int     LOCK_LEN = 511;
    localparam int     WIN_LEN  = 1023;
    localparam int     ERR_THR  = 0;
    localparam int     LOSS_THR = 64;
    localparam int     CNT_W    = 32;
    localparam int     SEQ_MAX  = 65536;
    localparam longint MAXC     = (longint'(1) << CNT_W) - 1;
    localparam int     M_SEED   = 0;
    localparam int     M_VERIFY = 1;
    localparam int     M_COUNT  = 2;

    logic                  clk = 1'b0;
    logic                  i_reset, i_en_rate1, i_clr_cnt;
    logic [N_CH-1:0]       i_rx_bits;
    logic [N_CH-1:0]       o_locked, o_ber_ok;
    logic [N_CH*CNT_W-1:0] o_err_cnt, o_bit_cnt;
    logic [0:0]            rx2, locked2, ok2;
    logic [3:0]            err2, bit2;
    bit                    rx2_inv;

    int n_cmp, n_fail, cyc;

    ber_checker_nch #(
        .N_CH(N_CH), .PRBS_ORDER(ORDER), .LOCK_LEN(LOCK_LEN), .WIN_LEN(WIN_LEN),
        .ERR_THR(ERR_THR), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .i_reset(i_reset), .i_en_rate1(i_en_rate1), .i_rx_bits(i_rx_bits),
        .i_clr_cnt(i_clr_cnt), .o_locked(o_locked), .o_ber_ok(o_ber_ok),
        .o_err_cnt(o_err_cnt), .o_bit_cnt(o_bit_cnt)
    );

    // Narrow-counter instance whose loss threshold can never be reached.
    ber_checker_nch #(
        .N_CH(1), .PRBS_ORDER(ORDER), .LOCK_LEN(LOCK_LEN), .WIN_LEN(WIN_LEN),
        .ERR_THR(ERR_THR), .LOSS_THR(2000), .CNT_W(4)
    ) dut_sat (
        .clk(clk), .i_reset(i_reset), .i_en_rate1(i_en_rate1), .i_rx_bits(rx2),
        .i_clr_cnt(i_clr_cnt), .o_locked(locked2), .o_ber_ok(ok2),
        .o_err_cnt(err2), .o_bit_cnt(bit2)
    );

    always #5 clk = ~clk;

    int     m_mode[N_CH], m_scnt[N_CH], m_run[N_CH], m_wbits[N_CH], m_werr[N_CH], m_n[N_CH];
    bit     m_lock[N_CH], m_ok[N_CH];
    longint m_err[N_CH], m_bit[N_CH];
    bit     seq[N_CH][SEQ_MAX];
    logic [8:0] gen[N_CH];

    function automatic void model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_mode[k] = M_SEED; m_scnt[k] = 0; m_run[k] = 0;
            m_wbits[k] = 0; m_werr[k] = 0; m_lock[k] = 0; m_ok[k] = 0;
            m_err[k] = 0; m_bit[k] = 0; m_n[k] = ORDER;
            for (int i = 0; i < ORDER; i++) seq[k][i] = 1'b1;
        end
    endfunction

    // History holds every seeded or predicted symbol; a prediction is
    // b[n] = b[n-9] ^ b[n-5] over that history.
    function automatic void model_lane(input int k, input bit b);
        bit p, e;
        if (m_mode[k] == M_SEED) begin
            seq[k][m_n[k]] = b;
            m_n[k]++;
            m_scnt[k]++;
            if (m_scnt[k] == ORDER) begin m_mode[k] = M_VERIFY; m_run[k] = 0; end
        end else begin
            p = seq[k][m_n[k]-TAP_A] ^ seq[k][m_n[k]-TAP_B];
            seq[k][m_n[k]] = p;
            m_n[k]++;
            e = p ^ b;
            if (m_mode[k] == M_VERIFY) begin
                if (e) begin
                    m_mode[k] = M_SEED; m_scnt[k] = 0;
                end else begin
                    m_run[k]++;
                    if (m_run[k] == LOCK_LEN) begin
                        m_mode[k] = M_COUNT; m_lock[k] = 1; m_wbits[k] = 0; m_werr[k] = 0;
                    end
                end
            end else begin
                if (m_bit[k] < MAXC) m_bit[k]++;
                if (e) begin
                    if (m_err[k] < MAXC) m_err[k]++;
                    m_werr[k]++;
                end
                m_wbits[k]++;
                if (m_werr[k] >= LOSS_THR) begin
                    m_mode[k] = M_SEED; m_scnt[k] = 0; m_lock[k] = 0; m_ok[k] = 0;
                end else if (m_wbits[k] == WIN_LEN) begin
                    m_ok[k] = (m_werr[k] <= ERR_THR); m_wbits[k] = 0; m_werr[k] = 0;
                end
            end
        end
    endfunction

    function automatic void model_edge(input bit rst, input bit en, input bit clr,
                                       input logic [N_CH-1:0] rx);
        if (rst) begin
            model_reset();
            return;
        end
        if (en) for (int k = 0; k < N_CH; k++) model_lane(k, rx[k]);
        if (clr) for (int k = 0; k < N_CH; k++) begin m_err[k] = 0; m_bit[k] = 0; end
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_model();
        logic [N_CH-1:0]       el, eo;
        logic [N_CH*CNT_W-1:0] ee, eb;
        for (int k = 0; k < N_CH; k++) begin
            el[k] = m_lock[k];
            eo[k] = m_ok[k];
            ee[k*CNT_W +: CNT_W] = CNT_W'(m_err[k]);
            eb[k*CNT_W +: CNT_W] = CNT_W'(m_bit[k]);
        end
        n_cmp++;
        if ({o_locked, o_ber_ok, o_err_cnt, o_bit_cnt} !== {el, eo, ee, eb}) begin
            n_fail++;
            $display("[TB] FAIL model cyc=%0d locked act=%b req=%b ok act=%b req=%b err act=%h req=%h bits act=%h req=%h",
                     cyc, o_locked, el, o_ber_ok, eo, o_err_cnt, ee, o_bit_cnt, eb);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(i_reset, i_en_rate1, i_clr_cnt, i_rx_bits);
        cyc++;
        @(negedge clk);
        check_model();
    endtask

    task automatic tx_advance(output logic [N_CH-1:0] txb);
        logic b;
        for (int k = 0; k < N_CH; k++) begin
            b = gen[k][8] ^ gen[k][4];
            gen[k] = {gen[k][7:0], b};
            txb[k] = b;
        end
    endtask

    // One strobe carrying the next PRBS symbol (optionally flipped), then period-1 idle clocks.
    task automatic apply_stimulus(input logic [N_CH-1:0] flip, input bit clr, input int period);
        logic [N_CH-1:0] tx;
        tx_advance(tx);
        i_en_rate1 = 1'b1;
        i_clr_cnt  = clr;
        i_rx_bits  = tx ^ flip;
        rx2        = rx2_inv ? ~tx[0] : tx[0];
        tick();
        i_en_rate1 = 1'b0;
        i_clr_cnt  = 1'b0;
        for (int i = 1; i < period; i++) begin
            i_rx_bits = N_CH'($urandom);
            rx2       = 1'($urandom);
            tick();
        end
    endtask

    task automatic run_strobes(input int count, input int period, input int err_lane, input int n_err);
        logic [N_CH-1:0] flip;
        for (int s = 0; s < count; s++) begin
            flip = '0;
            if (err_lane >= 0 && s < 2 * n_err && (s % 2) == 0) flip[err_lane] = 1'b1;
            apply_stimulus(flip, 1'b0, period);
        end
    endtask

    typedef struct {
        int         strobes;
        int         err_lane;
        int         n_err;
        logic [1:0] exp_locked;
        logic [1:0] exp_ok;
        int         exp_err0;
        int         exp_err1;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N_CH-1:0] flip;
        n_cmp = 0; n_fail = 0; cyc = 0; rx2_inv = 0;
        i_reset = 1'b1; i_en_rate1 = 1'b0; i_clr_cnt = 1'b0; i_rx_bits = '0; rx2 = '0;
        for (int k = 0; k < N_CH; k++) gen[k] = 9'($urandom_range(1, 511));
        model_reset();

        // Phases from reset: lock, clean window, lane-1 single error, lane-0 loss and relock.
        vecs[0] = '{519,  -1, 0,  2'b00, 2'b00, 0,  0};
        vecs[1] = '{1,    -1, 0,  2'b11, 2'b00, 0,  0};
        vecs[2] = '{1023, -1, 0,  2'b11, 2'b11, 0,  0};
        vecs[3] = '{1023,  1, 1,  2'b11, 2'b01, 0,  1};
        vecs[4] = '{1023, -1, 0,  2'b11, 2'b11, 0,  1};
        vecs[5] = '{127,   0, 64, 2'b10, 2'b10, 64, 1};
        vecs[6] = '{519,  -1, 0,  2'b10, 2'b10, 64, 1};
        vecs[7] = '{1,    -1, 0,  2'b11, 2'b10, 64, 1};

        @(negedge clk);
        tick();
        tick();
        check_output("reset_locked", 64'(o_locked), 64'd0);
        check_output("reset_ok", 64'(o_ber_ok), 64'd0);
        check_output("reset_err", 64'(o_err_cnt), 64'd0);
        check_output("reset_sat_locked", 64'(locked2), 64'd0);
        i_reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run_strobes(vecs[v].strobes, 1, vecs[v].err_lane, vecs[v].n_err);
            check_output($sformatf("vec%0d_locked", v), 64'(o_locked), 64'(vecs[v].exp_locked));
            check_output($sformatf("vec%0d_ok", v), 64'(o_ber_ok), 64'(vecs[v].exp_ok));
            check_output($sformatf("vec%0d_err0", v), 64'(o_err_cnt[0 +: CNT_W]), 64'(vecs[v].exp_err0));
            check_output($sformatf("vec%0d_err1", v), 64'(o_err_cnt[CNT_W +: CNT_W]), 64'(vecs[v].exp_err1));
        end
        check_output("bits1_after_table", 64'(o_bit_cnt[CNT_W +: CNT_W]), 64'(3 * 1023 + 127 + 520));

        // Random strobes, sparse errors, a lane-1 error burst and occasional clears.
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                i_rx_bits = N_CH'($urandom);
                tick();
            end else begin
                flip = '0;
                for (int k = 0; k < N_CH; k++) if ($urandom_range(0, 1999) == 0) flip[k] = 1'b1;
                if (c >= 3000 && c < 3300 && $urandom_range(0, 1) == 1) flip[1] = 1'b1;
                apply_stimulus(flip, ($urandom_range(0, 399) == 0), 1);
            end
        end

        // Reset in the middle of a window with a strobe every 4th clock.
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        run_strobes(520 + 1023, 1, -1, 0);
        check_output("pre_reset_ok", 64'(o_ber_ok), 64'd3);
        run_strobes(300, 4, -1, 0);
        i_reset = 1'b1; i_en_rate1 = 1'b1; i_clr_cnt = 1'b1;
        tick();
        i_reset = 1'b0; i_en_rate1 = 1'b0; i_clr_cnt = 1'b0;
        check_output("midreset_locked", 64'(o_locked), 64'd0);
        check_output("midreset_ok", 64'(o_ber_ok), 64'd0);
        check_output("midreset_bits", 64'(o_bit_cnt), 64'd0);
        run_strobes(519, 4, -1, 0);
        check_output("relock4_before", 64'(o_locked), 64'd0);
        run_strobes(1, 4, -1, 0);
        check_output("relock4_at", 64'(o_locked), 64'd3);
        run_strobes(1022, 1, -1, 0);
        check_output("fresh_window_pending", 64'(o_ber_ok), 64'd0);
        run_strobes(1, 1, -1, 0);
        check_output("fresh_window_done", 64'(o_ber_ok), 64'd3);
        check_output("fresh_window_bits0", 64'(o_bit_cnt[0 +: CNT_W]), 64'd1023);

        // Clear coincident with an error increment.
        apply_stimulus(2'b10, 1'b0, 1);
        check_output("err1_before_clr", 64'(o_err_cnt[CNT_W +: CNT_W]), 64'd1);
        apply_stimulus(2'b10, 1'b1, 1);
        check_output("clr_err1", 64'(o_err_cnt[CNT_W +: CNT_W]), 64'd0);
        check_output("clr_bits0", 64'(o_bit_cnt[0 +: CNT_W]), 64'd0);
        apply_stimulus(2'b00, 1'b0, 1);
        check_output("after_clr_bits1", 64'(o_bit_cnt[CNT_W +: CNT_W]), 64'd1);

        // Saturation of 4-bit counters under continuous errors.
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        run_strobes(520, 1, -1, 0);
        check_output("sat_locked", 64'(locked2), 64'd1);
        check_output("sat_err_start", 64'(err2), 64'd0);
        rx2_inv = 1'b1;
        run_strobes(20, 1, -1, 0);
        check_output("sat_err", 64'(err2), 64'd15);
        check_output("sat_bits", 64'(bit2), 64'd15);
        check_output("sat_still_locked", 64'(locked2), 64'd1);
        apply_stimulus('0, 1'b1, 1);
        check_output("sat_clr_err", 64'(err2), 64'd0);
        apply_stimulus('0, 1'b0, 1);
        check_output("sat_after_clr_err", 64'(err2), 64'd1);
        rx2_inv = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
